// File: rtl/sys_led_ctrl.sv
// Sys-bus LED peripheral: per-channel direct/PWM/blink/off drive on a shared prescaled PWM timebase.
// Single-cycle registered ack; errors on unmapped offsets and writes to the read-only STATUS register.
module sys_led_ctrl #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned PWM_W     = 8,
   parameter int unsigned PRESC_W   = 16,
   parameter int unsigned PRESC_RST = 0
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [31:0]       sys_addr_i,
   input  logic [31:0]       sys_wdata_i,
   input  logic              sys_wen_i,
   input  logic              sys_ren_i,
   output logic [31:0]       sys_rdata_o,
   output logic              sys_err_o,
   output logic              sys_ack_o,
   output logic [NUM_CH-1:0] led_o
);

   localparam int unsigned AW = 20;
   localparam int unsigned WW = AW - 2;
   localparam logic [WW-1:0] W_DIRECT = WW'(0);
   localparam logic [WW-1:0] W_PRESC  = WW'(1);
   localparam logic [WW-1:0] W_STATUS = WW'(2);
   localparam int unsigned   W_CFG0   = 4;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'd0,
      MODE_PWM    = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_OFF    = 2'd3
   } mode_e;

   typedef struct packed {
      logic [PWM_W-1:0] duty;
      mode_e            mode;
   } ch_cfg_t;

   logic [NUM_CH-1:0]  led_direct;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] presc_cnt;
   logic [PWM_W-1:0]   pwm_cnt;
   ch_cfg_t            ch_cfg [NUM_CH];
   logic               ack;
   logic               err;
   logic [31:0]        rdata;
   logic [NUM_CH-1:0]  led;

   logic [AW-1:0]      off_c;
   logic [WW-1:0]      word_c;
   logic               aligned_c;
   logic               strobe_c;
   logic               hit_c;
   logic               ro_c;
   logic               err_c;
   logic               wr_c;
   logic               sel_dir_c;
   logic               sel_presc_c;
   logic [NUM_CH-1:0]  sel_cfg_c;
   logic [31:0]        rd_val_c;
   logic               tick_c;
   logic [NUM_CH-1:0]  led_nxt_c;
   logic               unused_c;

   assign off_c     = sys_addr_i[AW-1:0];
   assign word_c    = off_c[AW-1:2];
   assign aligned_c = (off_c[1:0] == 2'b00);
   assign strobe_c  = sys_wen_i | sys_ren_i;
   assign unused_c  = ^{sys_addr_i[31:AW], sys_wdata_i};

   // Address decode and read mux; the read value is always the pre-write content.
   always_comb begin
      hit_c       = 1'b0;
      ro_c        = 1'b0;
      sel_dir_c   = 1'b0;
      sel_presc_c = 1'b0;
      sel_cfg_c   = '0;
      rd_val_c    = '0;
      if (aligned_c) begin
         if (word_c == W_DIRECT) begin
            hit_c     = 1'b1;
            sel_dir_c = 1'b1;
            rd_val_c  = 32'(led_direct);
         end
         if (word_c == W_PRESC) begin
            hit_c       = 1'b1;
            sel_presc_c = 1'b1;
            rd_val_c    = 32'(presc);
         end
         if (word_c == W_STATUS) begin
            hit_c    = 1'b1;
            ro_c     = 1'b1;
            rd_val_c = {11'b0, 5'(NUM_CH), 16'(pwm_cnt)};
         end
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (word_c == WW'(W_CFG0 + c)) begin
               hit_c        = 1'b1;
               sel_cfg_c[c] = 1'b1;
               rd_val_c     = 32'({ch_cfg[c].duty, 6'b0, ch_cfg[c].mode});
            end
         end
      end
   end

   assign err_c  = ~hit_c | (sys_wen_i & ro_c);
   assign wr_c   = sys_wen_i & ~err_c;
   assign tick_c = (presc_cnt == presc);

   // Next LED value from the current configuration and counters.
   always_comb begin
      led_nxt_c = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         case (ch_cfg[c].mode)
            MODE_DIRECT: led_nxt_c[c] = led_direct[c];
            MODE_PWM:    led_nxt_c[c] = (pwm_cnt < ch_cfg[c].duty);
            MODE_BLINK:  led_nxt_c[c] = pwm_cnt[PWM_W-1];
            default:     led_nxt_c[c] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ack        <= 1'b0;
         err        <= 1'b0;
         rdata      <= '0;
         led        <= '0;
         led_direct <= '0;
         presc      <= PRESC_W'(PRESC_RST);
         presc_cnt  <= '0;
         pwm_cnt    <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_cfg[c] <= '0;
         end
      end else begin
         ack <= strobe_c;
         led <= led_nxt_c;
         if (strobe_c) begin
            err   <= err_c;
            rdata <= err_c ? 32'h0 : rd_val_c;
         end
         if (wr_c && sel_dir_c) begin
            led_direct <= sys_wdata_i[NUM_CH-1:0];
         end
         if (wr_c && sel_presc_c) begin
            presc <= sys_wdata_i[PRESC_W-1:0];
         end
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (wr_c && sel_cfg_c[c]) begin
               ch_cfg[c].duty <= sys_wdata_i[PWM_W+7:8];
               ch_cfg[c].mode <= mode_e'(sys_wdata_i[1:0]);
            end
         end
         // A prescaler write restarts the whole timebase in phase with the new value.
         if (wr_c && sel_presc_c) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
         end else if (tick_c) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + PWM_W'(1);
         end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
         end
      end
   end

   assign sys_ack_o   = ack;
   assign sys_err_o   = err;
   assign sys_rdata_o = rdata;
   assign led_o       = led;

endmodule
